// File: rtl/burgertime_pkg.sv
// Shared BurgerTime definitions.
// Contents:
//   - USB keycodes for the W/A/S/D movement keys.
//   - dir_t facing/direction encoding, as used by the sprite ROM.
//   - Playfield limits, shared with stages_walls.
package burgertime_pkg;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    localparam int PF_X_MIN = 0;
    localparam int PF_X_MAX = 192;
    localparam int PF_Y_MIN = 0;
    localparam int PF_Y_MAX = 141;

endpackage

// File: rtl/chef_motion_if.sv
// Chef motion bus.
// Groups the keyboard/wall-checker inputs and the position/sprite outputs of
// chef_motion.
// Modports:
//   - master: the game logic side; drives keycode, move_valid and freeze.
//   - slave:  the chef_motion side; drives position, facing, animation frame
//             and the Moving flag.
interface chef_motion_if;
    logic [7:0] keycode;
    logic       move_valid;
    logic       freeze;
    logic [9:0] Chef_X_Pos;
    logic [9:0] Chef_Y_Pos;
    logic [1:0] Chef_Dir;
    logic [1:0] Anim_Frame;
    logic       Moving;

    modport master (
        output keycode, move_valid, freeze,
        input  Chef_X_Pos, Chef_Y_Pos, Chef_Dir, Anim_Frame, Moving
    );

    modport slave (
        input  keycode, move_valid, freeze,
        output Chef_X_Pos, Chef_Y_Pos, Chef_Dir, Anim_Frame, Moving
    );
endinterface

// File: rtl/chef_step_timer.sv
// Movement pacing timer: divides the frame clock into movement ticks.
// Ports:
//   - clk     frame clock
//   - rst_n   synchronous active-low reset
//   - hold    freezes the counter
//   - en      counting enable (chef not idle)
//   - clear   restart pacing from zero
//   - req_vld a movement request is present this frame
//   - tick    move one step on this edge
module chef_step_timer #(
    parameter int STEP_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic en,
    input  logic clear,
    input  logic req_vld,
    output logic tick
);
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] step_cnt;

    // A clear (direction change or going idle) swallows the tick so that the
    // next step always lands a full STEP_DIV frames later.
    assign tick = en && req_vld && !clear && !hold && (step_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (!hold) begin
            if (clear) begin
                step_cnt <= '0;
            end else if (en) begin
                step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/chef_motion.sv
// Chef motion controller.
// Turns the registered wall-checker verdict plus the (one-frame delayed)
// keycode into a paced, clamped chef position, a facing direction and a
// walk-animation frame for the sprite ROM.
// Ports:
//   - frame_clk  frame-rate clock
//   - Reset_n    synchronous active-low reset
//   - bus        chef_motion_if.slave
//                  in:  keycode, move_valid, freeze
//                  out: Chef_X_Pos, Chef_Y_Pos, Chef_Dir, Anim_Frame, Moving
module chef_motion
    import burgertime_pkg::*;
#(
    parameter int STEP_DIV = 2,
    parameter int STEP_PX  = 1,
    parameter int START_X  = 96,
    parameter int START_Y  = 141,
    parameter int X_MIN    = PF_X_MIN,
    parameter int X_MAX    = PF_X_MAX,
    parameter int Y_MIN    = PF_Y_MIN,
    parameter int Y_MAX    = PF_Y_MAX
) (
    input logic          frame_clk,
    input logic          Reset_n,
    chef_motion_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_H = 2'd1,
        CLIMB  = 2'd2
    } state_t;

    localparam logic signed [10:0] STEP_S = 11'(STEP_PX);
    localparam logic signed [10:0] X_LO   = 11'(X_MIN);
    localparam logic signed [10:0] X_HI   = 11'(X_MAX);
    localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_HI   = 11'(Y_MAX);

    function automatic logic [9:0] sat(
        input logic signed [10:0] v,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        logic signed [10:0] r;
        if (v < lo)      r = lo;
        else if (v > hi) r = hi;
        else             r = v;
        return r[9:0];
    endfunction

    state_t     state, state_nxt;
    logic [7:0] key_q;
    logic [9:0] x_q, y_q, x_nxt, y_nxt;
    dir_t       dir_q;
    logic [1:0] anim_q;
    logic       moving_q;

    logic       req_vld;
    dir_t       req_dir;
    logic       tick;
    logic       clear;
    logic       moved;
    logic signed [10:0] x_ext, y_ext;

    // The wall checker judged last frame's key, so key_q (not the live
    // keycode) is what move_valid refers to.
    always_comb begin
        req_vld = 1'b0;
        req_dir = RIGHT;
        if (bus.move_valid) begin
            unique case (key_q)
                KEY_A: begin req_vld = 1'b1; req_dir = LEFT;  end
                KEY_D: begin req_vld = 1'b1; req_dir = RIGHT; end
                KEY_W: begin req_vld = 1'b1; req_dir = UP;    end
                KEY_S: begin req_vld = 1'b1; req_dir = DOWN;  end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (!req_vld)
            state_nxt = IDLE;
        else if (req_dir == LEFT || req_dir == RIGHT)
            state_nxt = WALK_H;
        else
            state_nxt = CLIMB;
    end

    assign clear = (state_nxt == IDLE) || (req_vld && (req_dir != dir_q));

    chef_step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
        .clk     (frame_clk),
        .rst_n   (Reset_n),
        .hold    (bus.freeze),
        .en      (state != IDLE),
        .clear   (clear),
        .req_vld (req_vld),
        .tick    (tick)
    );

    // Work in 11-bit signed so that stepping below zero or past the far edge
    // saturates instead of wrapping.
    assign x_ext = signed'({1'b0, x_q});
    assign y_ext = signed'({1'b0, y_q});

    always_comb begin
        x_nxt = x_q;
        y_nxt = y_q;
        if (tick) begin
            unique case (req_dir)
                LEFT:  x_nxt = sat(x_ext - STEP_S, X_LO, X_HI);
                RIGHT: x_nxt = sat(x_ext + STEP_S, X_LO, X_HI);
                UP:    y_nxt = sat(y_ext - STEP_S, Y_LO, Y_HI);
                DOWN:  y_nxt = sat(y_ext + STEP_S, Y_LO, Y_HI);
                default: ;
            endcase
        end
    end

    // A tick that is fully absorbed by the clamp does not animate.
    assign moved = (x_nxt != x_q) || (y_nxt != y_q);

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            key_q    <= 8'h00;
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            dir_q    <= RIGHT;
            anim_q   <= 2'd0;
            moving_q <= 1'b0;
        end else if (!bus.freeze) begin
            state    <= state_nxt;
            key_q    <= bus.keycode;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            moving_q <= (state_nxt != IDLE);
            if (req_vld)
                dir_q <= req_dir;
            if (state_nxt == IDLE)
                anim_q <= 2'd0;
            else if (moved)
                anim_q <= anim_q + 2'd1;
        end
    end

    assign bus.Chef_X_Pos = x_q;
    assign bus.Chef_Y_Pos = y_q;
    assign bus.Chef_Dir   = dir_q;
    assign bus.Anim_Frame = anim_q;
    assign bus.Moving     = moving_q;
endmodule

// File: tb/tb_chef_motion.sv
// Testbench for chef_motion: a table of hand-derived vectors, a left-edge
// clamp sequence and a randomized run checked against a frame-level model.
module tb_chef_motion;
    import burgertime_pkg::*;

    localparam int DIV = 2;
    localparam int PX  = 1;

    logic frame_clk = 1'b0;
    logic Reset_n;
    chef_motion_if bus ();

    chef_motion #(
        .STEP_DIV(DIV), .STEP_PX(PX), .START_X(96), .START_Y(141),
        .X_MIN(0), .X_MAX(192), .Y_MIN(0), .Y_MAX(141)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Frame-level behavioural model: mode 0 = standing, 1 = horizontal,
    // 2 = vertical; direction uses the 0..3 facing code.
    int m_x, m_y, m_dir, m_anim, m_cnt, m_mode;
    logic [7:0] m_kq;

    task automatic model_step(input logic rst_n, input logic [7:0] key,
                              input logic mv, input logic frz);
        int r;
        int nx, ny;
        if (!rst_n) begin
            m_x = 96; m_y = 141; m_dir = 1; m_anim = 0; m_cnt = 0;
            m_mode = 0; m_kq = 8'h00;
        end else if (!frz) begin
            r = -1;
            if (mv) begin
                if (m_kq == 8'h04) r = 0;
                else if (m_kq == 8'h07) r = 1;
                else if (m_kq == 8'h1A) r = 2;
                else if (m_kq == 8'h16) r = 3;
            end
            if (r < 0) begin
                m_mode = 0; m_cnt = 0; m_anim = 0;
            end else begin
                if (r != m_dir) begin
                    m_cnt = 0;
                end else if (m_mode != 0) begin
                    if (m_cnt == DIV - 1) begin
                        m_cnt = 0;
                        nx = m_x; ny = m_y;
                        if (r == 0) nx = (m_x - PX < 0) ? 0 : m_x - PX;
                        if (r == 1) nx = (m_x + PX > 192) ? 192 : m_x + PX;
                        if (r == 2) ny = (m_y - PX < 0) ? 0 : m_y - PX;
                        if (r == 3) ny = (m_y + PX > 141) ? 141 : m_y + PX;
                        if (nx != m_x || ny != m_y) m_anim = (m_anim + 1) % 4;
                        m_x = nx; m_y = ny;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                m_dir  = r;
                m_mode = (r < 2) ? 1 : 2;
            end
            m_kq = key;
        end
    endtask

    // Drive one frame, let the edge happen, advance the model with the same
    // inputs, then sample outputs 1 time unit after the edge.
    task automatic frame(input logic rst_n, input logic [7:0] key,
                         input logic mv, input logic frz);
        Reset_n        = rst_n;
        bus.keycode    = key;
        bus.move_valid = mv;
        bus.freeze     = frz;
        @(posedge frame_clk);
        model_step(rst_n, key, mv, frz);
        #1;
    endtask

    task automatic check_out(input string name, input int ex, input int ey,
                             input int edir, input int eanim, input logic emov);
        n_vec++;
        if (int'(bus.Chef_X_Pos) != ex || int'(bus.Chef_Y_Pos) != ey ||
            int'(bus.Chef_Dir) != edir || int'(bus.Anim_Frame) != eanim ||
            bus.Moving != emov) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d dir=%0d anim=%0d mov=%0b, want x=%0d y=%0d dir=%0d anim=%0d mov=%0b",
                     name, bus.Chef_X_Pos, bus.Chef_Y_Pos, bus.Chef_Dir,
                     bus.Anim_Frame, bus.Moving, ex, ey, edir, eanim, emov);
        end
    endtask

    task automatic check_model(input string name);
        check_out(name, m_x, m_y, m_dir, m_anim, (m_mode != 0));
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] key;
        logic       mv;
        logic       frz;
        int         ex;
        int         ey;
        int         edir;
        int         eanim;
        logic       emov;
    } vec_t;

    localparam int NV = 38;
    vec_t tbl [NV];

    initial begin
        int anim_hold;
        logic [7:0] rkey;
        logic       rmv, rfrz, rrst;

        // reset
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0,  96, 141, 1, 0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0,  96, 141, 1, 0, 1'b0};
        // walk right: verdict one frame after the key
        tbl[2]  = '{1'b1, 8'h07, 1'b0, 1'b0,  96, 141, 1, 0, 1'b0};
        tbl[3]  = '{1'b1, 8'h07, 1'b1, 1'b0,  96, 141, 1, 0, 1'b1};
        tbl[4]  = '{1'b1, 8'h07, 1'b1, 1'b0,  96, 141, 1, 0, 1'b1};
        tbl[5]  = '{1'b1, 8'h07, 1'b1, 1'b0,  97, 141, 1, 1, 1'b1};
        tbl[6]  = '{1'b1, 8'h07, 1'b1, 1'b0,  97, 141, 1, 1, 1'b1};
        tbl[7]  = '{1'b1, 8'h07, 1'b1, 1'b0,  98, 141, 1, 2, 1'b1};
        tbl[8]  = '{1'b1, 8'h07, 1'b1, 1'b0,  98, 141, 1, 2, 1'b1};
        tbl[9]  = '{1'b1, 8'h07, 1'b1, 1'b0,  99, 141, 1, 3, 1'b1};
        tbl[10] = '{1'b1, 8'h07, 1'b1, 1'b0,  99, 141, 1, 3, 1'b1};
        tbl[11] = '{1'b1, 8'h07, 1'b1, 1'b0, 100, 141, 1, 0, 1'b1};
        // wall rejection of W
        tbl[12] = '{1'b1, 8'h1A, 1'b0, 1'b0, 100, 141, 1, 0, 1'b0};
        tbl[13] = '{1'b1, 8'h1A, 1'b0, 1'b0, 100, 141, 1, 0, 1'b0};
        // W accepted: climb up
        tbl[14] = '{1'b1, 8'h1A, 1'b1, 1'b0, 100, 141, 2, 0, 1'b1};
        tbl[15] = '{1'b1, 8'h1A, 1'b1, 1'b0, 100, 141, 2, 0, 1'b1};
        tbl[16] = '{1'b1, 8'h1A, 1'b1, 1'b0, 100, 140, 2, 1, 1'b1};
        // switch to S mid-step: pacing restarts
        tbl[17] = '{1'b1, 8'h16, 1'b1, 1'b0, 100, 140, 2, 1, 1'b1};
        tbl[18] = '{1'b1, 8'h16, 1'b1, 1'b0, 100, 140, 3, 1, 1'b1};
        tbl[19] = '{1'b1, 8'h16, 1'b1, 1'b0, 100, 140, 3, 1, 1'b1};
        tbl[20] = '{1'b1, 8'h16, 1'b1, 1'b0, 100, 141, 3, 2, 1'b1};
        tbl[21] = '{1'b1, 8'h16, 1'b1, 1'b0, 100, 141, 3, 2, 1'b1};
        // bottom clamp: no move, no animation
        tbl[22] = '{1'b1, 8'h16, 1'b1, 1'b0, 100, 141, 3, 2, 1'b1};
        // turn right, then freeze with the counter mid-count
        tbl[23] = '{1'b1, 8'h07, 1'b1, 1'b0, 100, 141, 3, 2, 1'b1};
        tbl[24] = '{1'b1, 8'h07, 1'b1, 1'b0, 100, 141, 1, 2, 1'b1};
        tbl[25] = '{1'b1, 8'h07, 1'b1, 1'b0, 100, 141, 1, 2, 1'b1};
        tbl[26] = '{1'b1, 8'h07, 1'b1, 1'b1, 100, 141, 1, 2, 1'b1};
        tbl[27] = '{1'b1, 8'h07, 1'b1, 1'b1, 100, 141, 1, 2, 1'b1};
        tbl[28] = '{1'b1, 8'h07, 1'b1, 1'b1, 100, 141, 1, 2, 1'b1};
        tbl[29] = '{1'b1, 8'h07, 1'b1, 1'b1, 100, 141, 1, 2, 1'b1};
        tbl[30] = '{1'b1, 8'h07, 1'b1, 1'b1, 100, 141, 1, 2, 1'b1};
        tbl[31] = '{1'b1, 8'h07, 1'b1, 1'b0, 101, 141, 1, 3, 1'b1};
        tbl[32] = '{1'b1, 8'h07, 1'b1, 1'b0, 101, 141, 1, 3, 1'b1};
        // reset mid-walk, and reset beating freeze
        tbl[33] = '{1'b0, 8'h07, 1'b1, 1'b0,  96, 141, 1, 0, 1'b0};
        tbl[34] = '{1'b0, 8'h07, 1'b1, 1'b1,  96, 141, 1, 0, 1'b0};
        // key_q was cleared by reset, so the first verdict sees no key
        tbl[35] = '{1'b1, 8'h07, 1'b1, 1'b0,  96, 141, 1, 0, 1'b0};
        tbl[36] = '{1'b1, 8'h00, 1'b1, 1'b0,  96, 141, 1, 0, 1'b1};
        tbl[37] = '{1'b1, 8'h00, 1'b1, 1'b0,  96, 141, 1, 0, 1'b0};

        Reset_n = 1'b0; bus.keycode = 8'h00; bus.move_valid = 1'b0; bus.freeze = 1'b0;
        m_x = 0; m_y = 0; m_dir = 0; m_anim = 0; m_cnt = 0; m_mode = 0; m_kq = 8'h00;

        for (int i = 0; i < NV; i++) begin
            frame(tbl[i].rst_n, tbl[i].key, tbl[i].mv, tbl[i].frz);
            check_out($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey,
                      tbl[i].edir, tbl[i].eanim, tbl[i].emov);
        end

        // Left edge: hold A long enough to walk from 96 to 0 and beyond.
        frame(1'b0, 8'h00, 1'b0, 1'b0);
        check_model("clamp_rst");
        for (int i = 0; i < 220; i++) begin
            frame(1'b1, 8'h04, 1'b1, 1'b0);
            check_model($sformatf("clamp_walk%0d", i));
        end
        check_out("clamp_at_zero", 0, 141, 0, int'(bus.Anim_Frame), 1'b1);
        anim_hold = int'(bus.Anim_Frame);
        for (int i = 0; i < 8; i++) frame(1'b1, 8'h04, 1'b1, 1'b0);
        check_out("clamp_no_anim", 0, 141, 0, anim_hold, 1'b1);

        // Randomized run against the model.
        rkey = 8'h07;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: rkey = 8'h04;
                    1: rkey = 8'h07;
                    2: rkey = 8'h1A;
                    3: rkey = 8'h16;
                    default: rkey = 8'($urandom);
                endcase
            end
            rmv  = ($urandom_range(0, 99) < 85);
            rfrz = ($urandom_range(0, 99) < 5);
            rrst = !($urandom_range(0, 199) == 0);
            frame(rrst, rkey, rmv, rfrz);
            check_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
